// File: rtl/shift_right_seq_if.sv
// Request/response bundle for the sequential right shifter/rotator.
// The tb side drives the request (master), the shifter answers (slave).
// Optional macro SHIFT_RIGHT_STICKY_EN adds the sticky flag to the bundle.
interface shift_right_seq_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] src;
    logic [AMT_W-1:0] amt;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
`ifdef SHIFT_RIGHT_STICKY_EN
    logic             sticky;

    modport master (
        output start, src, amt, mode,
        input  busy, done, res, sticky
    );

    modport slave (
        input  start, src, amt, mode,
        output busy, done, res, sticky
    );
`else
    modport master (
        output start, src, amt, mode,
        input  busy, done, res
    );

    modport slave (
        input  start, src, amt, mode,
        output busy, done, res
    );
`endif
endinterface

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter/rotator, one bit position per clock.
// Modes: 00 logical, 01 arithmetic, 10 rotate right, 11 same as logical.
// Optional macro SHIFT_RIGHT_STICKY_EN: adds a sticky flag that reports
// whether any 1 bit fell off the LSB end in logical/arithmetic mode.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; done pulses here for one cycle
// S_SHIFT | shifting one bit per edge until the count reaches zero
module shift_right_seq #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    shift_right_seq_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             msb_in;
`ifdef SHIFT_RIGHT_STICKY_EN
    logic             acc_q, acc_d;
    logic             sticky_q, sticky_d;
`endif

    // Bit entering at the MSB for the current mode.
    always_comb begin
        msb_in = 1'b0;
        case (mode_q)
            MODE_ARITH: msb_in = sh_q[WIDTH-1];
            MODE_ROT:   msb_in = sh_q[0];
            default:    msb_in = 1'b0;
        endcase
    end

    // Next-state and datapath update for the two-state sequencer.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        res_d   = res_q;
        done_d  = 1'b0;
`ifdef SHIFT_RIGHT_STICKY_EN
        acc_d    = acc_q;
        sticky_d = sticky_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sh_d    = bus.src;
                    cnt_d   = bus.amt;
                    mode_d  = bus.mode;
                    state_d = S_SHIFT;
`ifdef SHIFT_RIGHT_STICKY_EN
                    acc_d   = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    sh_d  = {msb_in, sh_q[WIDTH-1:1]};
                    cnt_d = cnt_q - AMT_W'(1);
`ifdef SHIFT_RIGHT_STICKY_EN
                    // Rotation loses no bits, so it never feeds the flag.
                    if (mode_q != MODE_ROT) begin
                        acc_d = acc_q | sh_q[0];
                    end
`endif
                end else begin
                    res_d   = sh_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
`ifdef SHIFT_RIGHT_STICKY_EN
                    sticky_d = acc_q;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

`ifdef SHIFT_RIGHT_STICKY_EN
    // Sticky accumulator and its published copy, updated with res.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.sticky = sticky_q;
`endif

    // busy covers the shift phase plus the done cycle, so the earliest
    // accepted follow-on start is the edge that ends the done cycle.
    assign bus.busy = (state_q == S_SHIFT) || done_q;
    assign bus.done = done_q;
    assign bus.res  = res_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: directed operations with literal expectations,
// plus a cycle-level reference model compared on every falling edge.
module tb_shift_right_seq;

    localparam int W = 16;
    localparam int A = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    shift_right_seq_if #(.WIDTH(W), .AMT_W(A)) bus ();

    shift_right_seq #(.WIDTH(W), .AMT_W(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails < 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result from the operation's definition.
    function automatic logic [W-1:0] ref_res(input logic [W-1:0] s, input logic [A-1:0] a,
                                             input logic [1:0] m);
        logic signed [W-1:0] ss;
        logic [2*W-1:0]      dbl;
        ss  = s;
        dbl = {s, s} >> (int'(a) % W);
        case (m)
            2'b01:   return ss >>> a;
            2'b10:   return dbl[W-1:0];
            default: return s >> a;
        endcase
    endfunction

    function automatic logic ref_stk(input logic [W-1:0] s, input logic [A-1:0] a,
                                     input logic [1:0] m);
        logic [W-1:0] mask;
        mask = (W'(1) << a) - W'(1);
        if (m == 2'b10) return 1'b0;
        return |(s & mask);
    endfunction

    // Model: m_left counts busy cycles still to come (incl. the current one).
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_stk = 1'b0;
    logic [W-1:0] p_res = '0;
    logic         p_stk = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_stk  = 1'b0;
        end else begin
            logic accept;
            accept = bus.start && (m_left <= 1);
            if (m_left > 0) m_left--;
            if (accept) begin
                m_left = int'(bus.amt) + 2;
                p_res  = ref_res(bus.src, bus.amt, bus.mode);
                p_stk  = ref_stk(bus.src, bus.amt, bus.mode);
            end
            m_done = (m_left == 1);
            if (m_done) begin
                m_res = p_res;
                m_stk = p_stk;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_busy", 32'(bus.busy), 32'(m_left > 0));
        chk("model_done", 32'(bus.done), 32'(m_done));
        chk("model_res", 32'(bus.res), 32'(m_res));
`ifdef SHIFT_RIGHT_STICKY_EN
        chk("model_sticky", 32'(bus.sticky), 32'(m_stk));
`endif
    end

    task automatic run_op(input logic [W-1:0] s, input logic [A-1:0] a, input logic [1:0] m,
                          input logic [W-1:0] exp, input logic exp_stk, input string nm);
        int  edges;
        int  busy_cnt;
        bit  got;
        bus.src   = s;
        bus.amt   = a;
        bus.mode  = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        edges    = 1;
        busy_cnt = bus.busy ? 1 : 0;
        got      = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.busy) busy_cnt++;
            if (bus.done) got = 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, 32'(edges), 32'(int'(a) + 2));
        chk({nm, "_res"}, 32'(bus.res), 32'(exp));
        chk({nm, "_busy_len"}, 32'(busy_cnt), 32'(int'(a) + 2));
`ifdef SHIFT_RIGHT_STICKY_EN
        chk({nm, "_sticky"}, 32'(bus.sticky), 32'(exp_stk));
`else
        if (exp_stk) begin end
`endif
        @(posedge clk);
        #1;
        chk({nm, "_busy_drop"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.src   = '0;
        bus.amt   = '0;
        bus.mode  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_res", 32'(bus.res), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(16'hF0F0, 4'd4, 2'b00, 16'h0F0F, 1'b0, "logical");
        run_op(16'h8001, 4'd3, 2'b01, 16'hF000, 1'b1, "arith_neg");
        run_op(16'h7FFF, 4'd15, 2'b01, 16'h0000, 1'b1, "arith_pos15");
        run_op(16'h8000, 4'd15, 2'b01, 16'hFFFF, 1'b0, "arith_neg15");
        run_op(16'h0001, 4'd1, 2'b10, 16'h8000, 1'b0, "rot1");
        run_op(16'h1234, 4'd15, 2'b10, 16'h2468, 1'b0, "rot15");
        run_op(16'hABCD, 4'd0, 2'b00, 16'hABCD, 1'b0, "amt0");
        run_op(16'h8000, 4'd1, 2'b11, 16'h4000, 1'b0, "mode11");

        // start while busy is ignored
        bus.src = 16'hFFFF; bus.amt = 4'd8; bus.mode = 2'b00; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 begin bus.src = 16'h0000; bus.amt = 4'd0; bus.start = 1'b1; end
        @(posedge clk);
        #1 bus.start = 1'b0;
        begin
            int n;
            n = 0;
            while (!bus.done && n < 40) begin
                @(posedge clk);
                #1 n++;
            end
            chk("ignored_start_done", 32'(bus.done), 32'd1);
            chk("ignored_start_res", 32'(bus.res), 32'h00FF);
        end
        @(posedge clk);
        #1;

        // reset mid-operation: abort with no done pulse
        bus.src = 16'hFFFF; bus.amt = 4'd8; bus.mode = 2'b00; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_res", 32'(bus.res), 32'd0);
        begin
            bit seen;
            seen = 1'b0;
            repeat (12) begin
                @(posedge clk);
                #1 if (bus.done) seen = 1'b1;
            end
            chk("abort_no_done", 32'(seen), 32'd0);
        end

        run_op(16'h1234, 4'd2, 2'b00, 16'h048D, 1'b0, "after_reset");

`ifdef SHIFT_RIGHT_STICKY_EN
        run_op(16'h0011, 4'd4, 2'b00, 16'h0001, 1'b1, "stk_set");
        run_op(16'h0010, 4'd4, 2'b00, 16'h0001, 1'b0, "stk_clear");
        run_op(16'h000F, 4'd4, 2'b10, 16'hF000, 1'b0, "stk_rot");
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_hold_res", 32'(bus.res), 32'h048D
`ifdef SHIFT_RIGHT_STICKY_EN
            ^ 32'h048D ^ 32'hF000
`endif
        );
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
